// File: rtl/pattern_check_arbiter.sv
// Round-robin arbiter time-sharing one 16-bit word-pair pattern checker between two requesters,
// with a valid/ready response channel and saturating per-requester match counters.
module pattern_check_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [15:0]      req_a0,
  input  logic [15:0]      req_b0,
  input  logic [15:0]      req_a1,
  input  logic [15:0]      req_b1,
  output logic [1:0]       req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic             resp_match,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] match_cnt0,
  output logic [CNT_W-1:0] match_cnt1
);

  typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

  // Odd bits 1..13 must differ, even bits 2..14 must agree.
  localparam logic [15:0]      OddMask  = 16'h2AAA;
  localparam logic [15:0]      EvenMask = 16'h5554;
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [15:0]      a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic             resp_id_q, resp_id_d;
  logic             resp_match_q, resp_match_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]       grant;
  logic [15:0]      diff;
  logic             match;

  always_comb begin
    diff  = a_q ^ b_q;
    match = a_q[0] & b_q[0] & ((diff & OddMask) == OddMask) &
            ((diff & EvenMask) == 16'h0000) & (a_q[15] | b_q[15]);
  end

  // ptr_q = 0 prefers requester 0 under contention.
  always_comb begin
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_id_d    = resp_id_q;
    resp_match_d = resp_match_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    req_ready    = 2'b00;
    unique case (state_q)
      StIdle: begin
        req_ready = grant;
        if (|grant) begin
          id_d    = grant[1];
          a_d     = grant[1] ? req_a1 : req_a0;
          b_d     = grant[1] ? req_b1 : req_b0;
          ptr_d   = ~grant[1];
          state_d = StEval;
        end
      end
      StEval: begin
        resp_id_d    = id_q;
        resp_match_d = match;
        state_d      = StResp;
        if (match && !id_q && cnt0_q != CntMax) cnt0_d = cnt0_q + 1'b1;
        if (match && id_q && cnt1_q != CntMax)  cnt1_d = cnt1_q + 1'b1;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_match_q <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_id_q    <= resp_id_d;
      resp_match_q <= resp_match_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_id    = resp_id_q;
  assign resp_match = resp_match_q;
  assign match_cnt0 = cnt0_q;
  assign match_cnt1 = cnt1_q;

endmodule

// File: tb/tb_pattern_check_arbiter.sv
// Scoreboard bench for pattern_check_arbiter: a cycle-level reference model predicts grants,
// latency and counters; a separate monitor checks every presented response against the queue.
module tb_pattern_check_arbiter;

  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [15:0]      req_a0, req_b0, req_a1, req_b1;
  logic [1:0]       req_ready;
  logic             resp_valid, resp_ready, resp_id, resp_match, clr_cnt;
  logic [CNT_W-1:0] match_cnt0, match_cnt1;

  pattern_check_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_match (resp_match),
    .clr_cnt    (clr_cnt),
    .match_cnt0 (match_cnt0),
    .match_cnt1 (match_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {bit id; bit match;} exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  // Model state: phase 0 waiting for a grant, 1 evaluating, 2 presenting a response.
  int m_phase = 0;
  int m_ptr = 0;
  int m_id = 0;
  bit m_match = 0;
  int m_cnt[2] = '{0, 0};

  function automatic bit ref_match(input logic [15:0] a, input logic [15:0] b);
    if (!(a[0] && b[0])) return 1'b0;
    for (int i = 1; i <= 13; i += 2) if (a[i] == b[i]) return 1'b0;
    for (int i = 2; i <= 14; i += 2) if (a[i] != b[i]) return 1'b0;
    return a[15] || b[15];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and predictor.
  always @(negedge clk) begin
    int chosen;
    int exp_rdy;
    if (rst) begin
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_resp_valid", int'(resp_valid), 0);
      check("rst_resp_id", int'(resp_id), 0);
      check("rst_resp_match", int'(resp_match), 0);
      check("rst_cnt0", int'(match_cnt0), 0);
      check("rst_cnt1", int'(match_cnt1), 0);
      m_phase = 0;
      m_ptr   = 0;
      m_cnt   = '{0, 0};
      q.delete();
    end else begin
      chosen = -1;
      if (m_phase == 0) begin
        if (req_valid[0] && req_valid[1]) chosen = m_ptr;
        else if (req_valid[0])            chosen = 0;
        else if (req_valid[1])            chosen = 1;
      end
      exp_rdy = (chosen >= 0) ? (1 << chosen) : 0;
      check("req_ready", int'(req_ready), exp_rdy);
      check("resp_valid", int'(resp_valid), int'(m_phase == 2));
      check("match_cnt0", int'(match_cnt0), m_cnt[0]);
      check("match_cnt1", int'(match_cnt1), m_cnt[1]);
      for (int i = 0; i < 2; i++) begin
        if (clr_cnt) m_cnt[i] = 0;
        else if (m_phase == 1 && m_match && m_id == i && m_cnt[i] < CMAX) m_cnt[i]++;
      end
      case (m_phase)
        0: if (chosen >= 0) begin
          m_id    = chosen;
          m_match = (chosen == 1) ? ref_match(req_a1, req_b1) : ref_match(req_a0, req_b0);
          q.push_back('{id: (chosen == 1), match: m_match});
          m_ptr   = 1 - chosen;
          m_phase = 1;
          accepts++;
        end
        1: m_phase = 2;
        default: if (resp_ready) m_phase = 0;
      endcase
    end
  end

  // Response monitor: fields must match the oldest outstanding request every cycle they are shown.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        check("resp_id", int'(resp_id), int'(q[0].id));
        check("resp_match", int'(resp_match), int'(q[0].match));
        if (resp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [15:0] a, input logic [15:0] b);
    if (id == 1) begin req_a1 = a; req_b1 = b; end
    else         begin req_a0 = a; req_b0 = b; end
    req_valid[id] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_ready[id]) begin
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        return;
      end
      @(posedge clk);
    end
    check("send_timeout", 0, 1);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (q.size() == 0) begin
        tick();
        return;
      end
      tick();
    end
    check("drain_timeout", int'(q.size()), 0);
  endtask

  task automatic wait_accepts(input int target);
    for (int k = 0; k < 100; k++) begin
      if (accepts >= target) return;
      tick();
    end
    check("accept_timeout", accepts, target);
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b1; clr_cnt = 1'b0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Continuous contention: grants alternate starting at requester 0.
    req_a0 = 16'hFFFF; req_b0 = 16'hD555; req_a1 = 16'hFFFF; req_b1 = 16'hD555;
    req_valid = 2'b11;
    wait_accepts(accepts + 6);
    req_valid = 2'b00;
    wait_idle();
    check("contention_cnt0", int'(match_cnt0), 3);
    check("contention_cnt1", int'(match_cnt1), 3);

    pulse_clr();
    send(0, 16'h8001, 16'hAAAB);
    wait_idle();
    check("single_cnt0", int'(match_cnt0), 1);

    send(1, 16'h8001, 16'h8001);
    wait_idle();
    send(1, 16'h0001, 16'h2AAB);
    wait_idle();
    check("nomatch_cnt1", int'(match_cnt1), 0);

    // Response back-pressure, with both requesters waiting.
    resp_ready = 1'b0;
    send(0, 16'hFFFF, 16'hD555);
    tick();
    req_valid = 2'b11;
    repeat (5) tick();
    resp_ready = 1'b1;
    wait_accepts(accepts + 1);
    req_valid = 2'b00;
    wait_idle();

    pulse_clr();
    repeat (5) begin
      send(0, 16'hFFFF, 16'hD555);
      wait_idle();
    end
    check("sat_cnt0", int'(match_cnt0), CMAX);

    // Clear coinciding with a matching evaluation.
    send(0, 16'hFFFF, 16'hD555);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    wait_idle();
    check("clr_wins_cnt0", int'(match_cnt0), 0);

    // Reset while a matching pair is being evaluated.
    send(0, 16'hFFFF, 16'hD555);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    check("grant_after_rst", int'(req_ready), 1);
    wait_accepts(accepts + 1);
    req_valid = 2'b00;
    wait_idle();

    for (int c = 0; c < 400; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      req_a0 = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h8001 : 16'($urandom);
      req_b0 = (r == 0) ? 16'hD555 : (r == 1) ? 16'hAAAB : 16'($urandom);
      r = $urandom_range(0, 3);
      req_a1 = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h8001 : 16'($urandom);
      req_b1 = (r == 0) ? 16'hD555 : (r == 1) ? 16'hAAAB : 16'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      clr_cnt = ($urandom_range(0, 19) == 0);
      tick();
    end
    req_valid = 2'b00; resp_ready = 1'b1; clr_cnt = 1'b0;
    wait_idle();
    repeat (3) tick();
    check("queue_empty", int'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
